// File: rtl/mac_wl_pkg.sv
// Shared types and default constants for the MAC array word-line interface.
package mac_wl_pkg;

  localparam int WL_ADDR_W      = 5;
  localparam int WL_DATA_W      = 8;
  localparam int WL_CNT_W       = 8;
  localparam int WL_SETTLE_DEF  = 4;
  localparam int WL_PULSE_DEF   = 10;
  localparam int WL_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECHG  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_READY   = 3'd4,
    ST_PULSE   = 3'd5,
    ST_RECOVER = 3'd6
  } wl_state_e;

endpackage

// File: rtl/mac_wl_array_if_decoder.sv
// Registered row-address to one-hot word-line select; clear wins over load.
module wl_onehot_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     clr,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   sel
);

  localparam int ROWS = 1 << ADDR_W;
  localparam logic [ROWS-1:0] ONE = ROWS'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  sel <= '0;
    else if (clr)    sel <= '0;
    else if (load)   sel <= ONE << addr;
  end

endmodule

// File: rtl/mac_wl_array_if.sv
// Array-side word-line responder: DAC load, discharge, row decode and timed WL pulse.
//   state   | meaning
//   IDLE    | no operation in progress
//   PRECHG  | word lines discharged for SETTLE_CYC cycles
//   ARMED   | waiting for an address op, times out to IDLE
//   DECODE  | row select settling for SETTLE_CYC cycles
//   READY   | decoded, waiting for assert or re-address
//   PULSE   | word line driven for PULSE_CYC cycles
//   RECOVER | drive and select dropped, completion strobe issued
module mac_wl_array_if
  import mac_wl_pkg::*;
#(
  parameter int ADDR_W      = WL_ADDR_W,
  parameter int DATA_W      = WL_DATA_W,
  parameter int SETTLE_CYC  = WL_SETTLE_DEF,
  parameter int PULSE_CYC   = WL_PULSE_DEF,
  parameter int ARM_TIMEOUT = WL_TIMEOUT_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [DATA_W-1:0]      wl_digital_vol,
  input  logic                   wl_dac_lock_en,
  input  logic [ADDR_W-1:0]      wl_addr,
  input  logic                   wl_pre_op_en,
  input  logic                   wl_addr_op_en,
  input  logic                   wl_assert_en,
  output logic [DATA_W-1:0]      dac_code,
  output logic                   dac_load,
  output logic                   wl_discharge,
  output logic [(1<<ADDR_W)-1:0] wl_sel,
  output logic                   wl_drive,
  output logic                   wl_over,
  output logic                   busy,
  output logic                   err_seq
);

  localparam logic [WL_CNT_W-1:0] SETTLE_L  = WL_CNT_W'(SETTLE_CYC);
  localparam logic [WL_CNT_W-1:0] PULSE_L   = WL_CNT_W'(PULSE_CYC);
  localparam logic [WL_CNT_W-1:0] TIMEOUT_L = WL_CNT_W'(ARM_TIMEOUT);

  wl_state_e             state_q, state_d;
  logic [WL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  err_d;
  logic                  dec_load;
  logic                  dec_clr;
  logic                  lock_ok;

  assign lock_ok = wl_dac_lock_en && (state_q != ST_PULSE);

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    dec_load = 1'b0;
    cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

    if (wl_dac_lock_en && state_q == ST_PULSE) err_d = 1'b1;

    if (wl_pre_op_en) begin
      state_d = ST_PRECHG;
      if (state_q == ST_PULSE) err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_PRECHG: if (cnt_q == 8'd1) state_d = ST_ARMED;
        ST_ARMED: begin
          if (wl_addr_op_en) begin
            state_d  = ST_DECODE;
            dec_load = 1'b1;
          end else begin
            if (wl_assert_en) err_d = 1'b1;
            if (cnt_q == 8'd1) state_d = ST_IDLE;
          end
        end
        ST_DECODE: begin
          if (wl_assert_en) err_d = 1'b1;
          if (cnt_q == 8'd1) state_d = ST_READY;
        end
        ST_READY: begin
          if (wl_addr_op_en) begin
            state_d  = ST_DECODE;
            dec_load = 1'b1;
          end else if (wl_assert_en) begin
            state_d = ST_PULSE;
          end
        end
        ST_PULSE:   if (cnt_q == 8'd1) state_d = ST_RECOVER;
        ST_RECOVER: state_d = ST_ARMED;
        default:    state_d = ST_IDLE;
      endcase
    end

    // Timers reload on every entry, including a pre-op restart of PRECHG.
    if (state_d != state_q || wl_pre_op_en) begin
      case (state_d)
        ST_PRECHG, ST_DECODE: cnt_d = SETTLE_L;
        ST_PULSE:             cnt_d = PULSE_L;
        ST_ARMED:             cnt_d = TIMEOUT_L;
        default:              cnt_d = '0;
      endcase
    end
  end

  assign dec_clr = !(state_d inside {ST_DECODE, ST_READY, ST_PULSE});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dac_code     <= '0;
      dac_load     <= 1'b0;
      wl_discharge <= 1'b0;
      wl_drive     <= 1'b0;
      wl_over      <= 1'b0;
      busy         <= 1'b0;
      err_seq      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dac_load     <= lock_ok;
      if (lock_ok) dac_code <= wl_digital_vol;
      wl_discharge <= (state_d == ST_PRECHG);
      wl_drive     <= (state_d == ST_PULSE);
      wl_over      <= (state_d == ST_RECOVER);
      busy         <= (state_d != ST_IDLE);
      err_seq      <= err_d;
    end
  end

  wl_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (dec_clr),
    .load      (dec_load),
    .addr      (wl_addr),
    .sel       (wl_sel)
  );

endmodule

// File: tb/tb_mac_wl_array_if.sv
// Directed bench for mac_wl_array_if with hand-computed cycle expectations.
module tb_mac_wl_array_if;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  wl_digital_vol;
  logic        wl_dac_lock_en;
  logic [4:0]  wl_addr;
  logic        wl_pre_op_en;
  logic        wl_addr_op_en;
  logic        wl_assert_en;
  logic [7:0]  dac_code;
  logic        dac_load;
  logic        wl_discharge;
  logic [31:0] wl_sel;
  logic        wl_drive;
  logic        wl_over;
  logic        busy;
  logic        err_seq;

  int n_chk = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  mac_wl_array_if dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .wl_digital_vol (wl_digital_vol),
    .wl_dac_lock_en (wl_dac_lock_en),
    .wl_addr        (wl_addr),
    .wl_pre_op_en   (wl_pre_op_en),
    .wl_addr_op_en  (wl_addr_op_en),
    .wl_assert_en   (wl_assert_en),
    .dac_code       (dac_code),
    .dac_load       (dac_load),
    .wl_discharge   (wl_discharge),
    .wl_sel         (wl_sel),
    .wl_drive       (wl_drive),
    .wl_over        (wl_over),
    .busy           (busy),
    .err_seq        (err_seq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic do_pre();
    wl_pre_op_en = 1'b1;
    step();
    wl_pre_op_en = 1'b0;
  endtask

  task automatic do_addr(input logic [4:0] a);
    wl_addr       = a;
    wl_addr_op_en = 1'b1;
    step();
    wl_addr_op_en = 1'b0;
  endtask

  task automatic do_assert();
    wl_assert_en = 1'b1;
    step();
    wl_assert_en = 1'b0;
  endtask

  task automatic do_lock(input logic [7:0] v);
    wl_digital_vol = v;
    wl_dac_lock_en = 1'b1;
    step();
    wl_dac_lock_en = 1'b0;
  endtask

  initial begin
    sys_rst_n      = 1'b0;
    wl_digital_vol = '0;
    wl_dac_lock_en = 1'b0;
    wl_addr        = '0;
    wl_pre_op_en   = 1'b0;
    wl_addr_op_en  = 1'b0;
    wl_assert_en   = 1'b0;
    repeat (3) step();
    check("rst_dac_code", dac_code, 0);
    check("rst_dac_load", dac_load, 0);
    check("rst_sel", wl_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_drive", wl_drive, 0);
    check("rst_dis", wl_discharge, 0);
    check("rst_over", wl_over, 0);
    check("rst_err", err_seq, 0);
    sys_rst_n = 1'b1;
    step();

    do_lock(8'h5A);
    check("lock_code", dac_code, 32'h5A);
    check("lock_load", dac_load, 1);
    step();
    check("lock_load_drop", dac_load, 0);

    // full write: pre-op, address 17, assert (first tried in DECODE)
    do_pre();
    for (int i = 1; i <= 4; i++) begin
      check("dis_hi", wl_discharge, 1);
      check("dis_sel0", wl_sel, 0);
      step();
    end
    check("dis_lo", wl_discharge, 0);
    check("armed_busy", busy, 1);
    do_addr(5'd17);
    check("sel17", wl_sel, 32'h0002_0000);
    do_assert();
    check("decode_assert_err", err_seq, 1);
    check("decode_assert_nodrive", wl_drive, 0);
    step();
    check("decode_err_drop", err_seq, 0);
    step();
    step();
    do_assert();
    for (int i = 1; i <= 10; i++) begin
      check("pulse_drive", wl_drive, 1);
      check("pulse_over0", wl_over, 0);
      step();
    end
    check("rec_drive0", wl_drive, 0);
    check("rec_over", wl_over, 1);
    check("rec_sel0", wl_sel, 0);
    step();
    check("over_drop", wl_over, 0);
    check("armed_again_busy", busy, 1);

    // re-addressing: 3 from ARMED, then 31 from READY; assert probes the settle edge
    do_addr(5'd3);
    check("sel3", wl_sel, 32'h0000_0008);
    step(); step(); step();
    do_assert();
    check("settle3_err", err_seq, 1);
    check("settle3_sel", wl_sel, 32'h0000_0008);
    do_addr(5'd31);
    check("sel31", wl_sel, 32'h8000_0000);
    check("readdr_err0", err_seq, 0);
    step(); step(); step();
    do_assert();
    check("settle31_err", err_seq, 1);
    check("settle31_nodrive", wl_drive, 0);
    do_assert();
    check("pulse2_drive", wl_drive, 1);
    check("pulse2_sel", wl_sel, 32'h8000_0000);
    check("pulse2_err0", err_seq, 0);

    // lock during PULSE is refused
    do_lock(8'h33);
    check("pulse_lock_code", dac_code, 32'h5A);
    check("pulse_lock_load", dac_load, 0);
    check("pulse_lock_err", err_seq, 1);
    step(); step();
    check("pulse_cyc5_drive", wl_drive, 1);

    // pre-op at pulse cycle 5 aborts without completion
    do_pre();
    check("abort_drive0", wl_drive, 0);
    check("abort_sel0", wl_sel, 0);
    check("abort_err", err_seq, 1);
    check("abort_dis", wl_discharge, 1);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_over", wl_over, 0);
      step();
    end
    // now 2 cycles into ARMED after the 4-cycle restart of PRECHG
    check("abort_armed_dis0", wl_discharge, 0);
    check("abort_armed_busy", busy, 1);

    // ARMED timeout: 2 ARMED cycles already seen, IDLE after 255 total
    repeat (252) step();
    check("timeout_busy_hi", busy, 1);
    step();
    check("timeout_busy_lo", busy, 0);
    check("timeout_sel0", wl_sel, 0);

    // reset in the middle of a pulse
    do_pre();
    repeat (4) step();
    do_addr(5'd9);
    check("sel9", wl_sel, 32'h0000_0200);
    repeat (4) step();
    do_assert();
    step(); step();
    check("pre_rst_drive", wl_drive, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_drive", wl_drive, 0);
    check("async_sel", wl_sel, 0);
    check("async_busy", busy, 0);
    check("async_code", dac_code, 0);
    check("async_over", wl_over, 0);
    step();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("post_rst_no_over", wl_over, 0);
      step();
    end
    check("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
